// File: rtl/uart_rx_core_pkg.sv
// Shared types for the UART receiver: FSM state encoding and default frame width.
package uart_rx_core_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core_sampler.sv
// Three-point majority sampler: captures RX_IN around mid-bit and votes the bit value.
module rx_data_sampler (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic [4:0] Prescale,
  input  logic [4:0] edge_cnt,
  output logic       sampled_bit
);

  logic [4:0] half;
  logic [2:0] samples;

  assign half = Prescale >> 1;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samples <= '0;
    end else begin
      if (edge_cnt == half - 5'd1) samples[0] <= RX_IN;
      if (edge_cnt == half)        samples[1] <= RX_IN;
      if (edge_cnt == half + 5'd1) samples[2] <= RX_IN;
    end
  end

  assign sampled_bit = (samples[0] & samples[1]) |
                       (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: start/data/parity/stop deframing with a one-cycle Data_Valid strobe.
// Define UART_RX_ERR_FLAGS_EN to add PAR_ERR/STP_ERR pulse outputs.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic [4:0]       Prescale,
  output logic             Data_Valid,
  output logic [WIDTH-1:0] P_DATA
`ifdef UART_RX_ERR_FLAGS_EN
  ,
  output logic             PAR_ERR,
  output logic             STP_ERR
`endif
);

  localparam int CW = $clog2(WIDTH);

  rx_state_e        state, state_nxt;
  logic [4:0]       edge_cnt;
  logic [4:0]       half;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_reg;
  logic             par_err, stp_err, stp_bad;
  logic             sampled_bit, vote_pt, last_edge, last_bit, glitch, frame_end;

  rx_data_sampler u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .Prescale    (Prescale),
    .edge_cnt    (edge_cnt),
    .sampled_bit (sampled_bit)
  );

  assign half      = Prescale >> 1;
  assign vote_pt   = (edge_cnt == half + 5'd2);
  assign last_edge = (edge_cnt == Prescale - 5'd1);
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));
  assign glitch    = (state == START) && vote_pt && sampled_bit;
  assign frame_end = (state == STOP) && last_edge;
  // At Prescale=6 the vote point is the last edge, so the stop check must see the live vote.
  assign stp_bad   = stp_err | (vote_pt & ~sampled_bit);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!RX_IN) state_nxt = START;
      START:   if (glitch) state_nxt = IDLE;
               else if (last_edge) state_nxt = DATA;
      DATA:    if (last_edge && last_bit) state_nxt = PAR_EN ? PARITY : STOP;
      PARITY:  if (last_edge) state_nxt = STOP;
      STOP:    if (last_edge) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      P_DATA     <= '0;
      Data_Valid <= 1'b0;
    end else begin
      Data_Valid <= 1'b0;
      if (state == IDLE || last_edge || glitch) edge_cnt <= '0;
      else                                      edge_cnt <= edge_cnt + 5'd1;

      unique case (state)
        IDLE: begin
          bit_cnt <= '0;
          par_err <= 1'b0;
          stp_err <= 1'b0;
        end
        DATA: begin
          if (vote_pt)   shift_reg <= {sampled_bit, shift_reg[WIDTH-1:1]};
          if (last_edge) bit_cnt   <= last_bit ? '0 : bit_cnt + CW'(1);
        end
        PARITY: begin
          if (vote_pt) par_err <= sampled_bit != (^shift_reg ^ PAR_TYP);
        end
        STOP: begin
          if (vote_pt) stp_err <= ~sampled_bit;
          if (last_edge && !par_err && !stp_bad) begin
            P_DATA     <= shift_reg;
            Data_Valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef UART_RX_ERR_FLAGS_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PAR_ERR <= 1'b0;
      STP_ERR <= 1'b0;
    end else begin
      PAR_ERR <= frame_end & par_err;
      STP_ERR <= frame_end & stp_bad;
    end
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = frame_end;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// Table-driven bench for uart_rx_core with a scoreboard queue of expected bytes.
module tb_uart_rx_core;

  typedef struct {
    logic [7:0] data;
    logic [4:0] presc;
    logic       par_en;
    logic       par_typ;
    logic       par_bit;
    logic       stop_bit;
    int         gap;
    logic       glitch;
    logic       exp_ok;
    logic       exp_perr;
    logic       exp_serr;
  } vec_t;

  logic       UART_CLK_tb = 1'b0;
  logic       RST_tb;
  logic       RX_IN_tb;
  logic       PAR_EN_tb;
  logic       PAR_TYP_tb;
  logic [4:0] Prescale_tb;
  logic       Data_Valid_tb;
  logic [7:0] P_DATA_tb;
`ifdef UART_RX_ERR_FLAGS_EN
  logic       PAR_ERR_tb;
  logic       STP_ERR_tb;
`endif

  int total = 0;
  int bad   = 0;
  int strobes = 0;
  int perrs = 0;
  int serrs = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  vec_t vecs[12];

  always #5 UART_CLK_tb = ~UART_CLK_tb;

  uart_rx_core dut (
    .CLK        (UART_CLK_tb),
    .RST        (RST_tb),
    .RX_IN      (RX_IN_tb),
    .PAR_EN     (PAR_EN_tb),
    .PAR_TYP    (PAR_TYP_tb),
    .Prescale   (Prescale_tb),
    .Data_Valid (Data_Valid_tb),
    .P_DATA     (P_DATA_tb)
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    .PAR_ERR    (PAR_ERR_tb),
    .STP_ERR    (STP_ERR_tb)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected byte.
  always @(negedge UART_CLK_tb) begin
    if (RST_tb === 1'b1 && Data_Valid_tb === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: P_DATA=%0h with no frame pending", P_DATA_tb);
      end else begin
        check("p_data", {24'h0, P_DATA_tb}, {24'h0, exp_q.pop_front()});
      end
    end
`ifdef UART_RX_ERR_FLAGS_EN
    if (RST_tb === 1'b1 && PAR_ERR_tb === 1'b1) perrs++;
    if (RST_tb === 1'b1 && STP_ERR_tb === 1'b1) serrs++;
`endif
  end

  task automatic send_bit(input logic b, input logic [4:0] p);
    RX_IN_tb = b;
    repeat (int'(p)) @(negedge UART_CLK_tb);
  endtask

  task automatic send_frame(input vec_t v);
    Prescale_tb = v.presc;
    PAR_EN_tb   = v.par_en;
    PAR_TYP_tb  = v.par_typ;
    if (v.exp_ok) exp_q.push_back(v.data);
    send_bit(1'b0, v.presc);
    for (int i = 0; i < 8; i++) send_bit(v.data[i], v.presc);
    if (v.par_en) send_bit(v.par_bit, v.presc);
    send_bit(v.stop_bit, v.presc);
    RX_IN_tb = 1'b1;
  endtask

  initial begin
    int base_strobes, base_perrs, base_serrs;
    int exp_strobes, exp_perrs, exp_serrs;

    //            data   presc  pe    pt    pbit  stop gap glitch ok    perr  serr
    vecs[0]  = '{8'hBB, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h02, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h01, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'hDD, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8'h05, 5'd8,  1'b1, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{8'hAA, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'h77, 5'd8,  1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{8'h3C, 5'd16, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{8'h03, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'hA5, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h5A, 5'd30, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'hC3, 5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1'b1};

    RST_tb = 1'b0;
    RX_IN_tb = 1'b1;
    PAR_EN_tb = 1'b1;
    PAR_TYP_tb = 1'b0;
    Prescale_tb = 5'd8;
    repeat (3) @(negedge UART_CLK_tb);
    check("rst_valid", {31'h0, Data_Valid_tb}, 32'h0);
    check("rst_p_data", {24'h0, P_DATA_tb}, 32'h0);
`ifdef UART_RX_ERR_FLAGS_EN
    check("rst_par_err", {31'h0, PAR_ERR_tb}, 32'h0);
    check("rst_stp_err", {31'h0, STP_ERR_tb}, 32'h0);
`endif
    RST_tb = 1'b1;
    repeat (4) @(negedge UART_CLK_tb);

    last_good = 8'h00;
    base_strobes = 0; base_perrs = 0; base_serrs = 0;
    exp_strobes = 0;  exp_perrs = 0;  exp_serrs = 0;

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].glitch) begin
        Prescale_tb = vecs[i].presc;
        RX_IN_tb = 1'b0;
        repeat (2) @(negedge UART_CLK_tb);
        RX_IN_tb = 1'b1;
        repeat (3 * int'(vecs[i].presc)) @(negedge UART_CLK_tb);
        check("glitch_strobes", strobes - base_strobes, 0);
      end
      send_frame(vecs[i]);
      if (vecs[i].exp_ok) begin
        exp_strobes++;
        last_good = vecs[i].data;
      end
      if (vecs[i].exp_perr) exp_perrs++;
      if (vecs[i].exp_serr) exp_serrs++;
      if (vecs[i].gap > 0) begin
        repeat (vecs[i].gap) @(negedge UART_CLK_tb);
        check($sformatf("strobes_%0d", i), strobes - base_strobes, exp_strobes);
        check($sformatf("pending_%0d", i), exp_q.size(), 0);
        check($sformatf("hold_%0d", i), {24'h0, P_DATA_tb}, {24'h0, last_good});
`ifdef UART_RX_ERR_FLAGS_EN
        check($sformatf("par_err_%0d", i), perrs - base_perrs, exp_perrs);
        check($sformatf("stp_err_%0d", i), serrs - base_serrs, exp_serrs);
`endif
        base_strobes = strobes; base_perrs = perrs; base_serrs = serrs;
        exp_strobes = 0;        exp_perrs = 0;      exp_serrs = 0;
      end
    end

    // Reset in the middle of the data bits of 0x55 must abort without a strobe.
    Prescale_tb = 5'd8;
    PAR_EN_tb = 1'b1;
    PAR_TYP_tb = 1'b0;
    send_bit(1'b0, 5'd8);
    send_bit(1'b1, 5'd8);
    send_bit(1'b0, 5'd8);
    send_bit(1'b1, 5'd8);
    RST_tb = 1'b0;
    RX_IN_tb = 1'b1;
    @(negedge UART_CLK_tb);
    check("midrst_valid", {31'h0, Data_Valid_tb}, 32'h0);
    check("midrst_p_data", {24'h0, P_DATA_tb}, 32'h0);
    repeat (3) @(negedge UART_CLK_tb);
    RST_tb = 1'b1;
    repeat (20) @(negedge UART_CLK_tb);
    check("midrst_strobes", strobes - base_strobes, 0);
    base_strobes = strobes;
    send_frame('{8'h55, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 6, 1'b0, 1'b1, 1'b0, 1'b0});
    repeat (6) @(negedge UART_CLK_tb);
    check("after_rst_strobes", strobes - base_strobes, 1);
    check("after_rst_pending", exp_q.size(), 0);
    check("after_rst_p_data", {24'h0, P_DATA_tb}, 32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
